// File: rtl/ws2812_pkg.sv
// Shared WS2812 constants and frame-sequencer state encoding.
package ws2812_pkg;

  localparam int BITS_PER_LED   = 24;
  // Must equal the encoder's T0H+T0L so pixel timing lines up.
  localparam int CYCLES_PER_BIT = 130;
  localparam int CYCLES_PER_LED = BITS_PER_LED * CYCLES_PER_BIT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer: streams NUM_LEDS GRB words from the colour buffer into the
// WS2812 encoder without gaps, then holds the line low for the latch period.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int RESET_CYCLES = 6000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       grb,
  output logic              enc_start,
  input  logic              enc_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [15:0]       LCNT_INIT = 16'(RESET_CYCLES - 1);

  state_t            r_state, w_nxt_state;
  logic [ADDR_W-1:0] r_idx;
  logic [23:0]       r_nxt_pix;
  logic [23:0]       r_grb;
  logic [15:0]       r_lcnt;
  logic              r_start, r_busy, r_pend;
  logic              w_last, w_lat_end, w_go;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_lat_end = (r_state == LATCH) && (r_lcnt == 16'd0);
  // A request landing on the final latch cycle restarts directly, like pending.
  assign w_go      = r_pend | frame_req;

  // Address is 0 outside SEND so rd_data already holds pixel 0 during LOAD.
  assign rd_addr    = (r_state == SEND && !w_last) ? r_idx + ADDR_W'(1) : '0;
  assign grb        = r_grb;
  assign enc_start  = r_start;
  assign frame_busy = r_busy;
  assign frame_done = w_lat_end;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt_state;
  end

  // Next-state logic.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:  if (frame_req) w_nxt_state = LOAD;
      LOAD:  w_nxt_state = SEND;
      SEND:  if (enc_done && w_last) w_nxt_state = LATCH;
      LATCH: if (r_lcnt == 16'd0) w_nxt_state = w_go ? LOAD : IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Pixel index, prefetch, encoder handshake and latch countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_nxt_pix <= '0;
      r_grb     <= '0;
      r_lcnt    <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_req) begin
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        LOAD: begin
          r_grb   <= rd_data;
          r_start <= 1'b1;
        end
        SEND: begin
          r_nxt_pix <= rd_data;
          // grb may only move on a pixel boundary; encoder samples it every cycle.
          if (enc_done) begin
            if (!w_last) begin
              r_grb <= r_nxt_pix;
              r_idx <= r_idx + ADDR_W'(1);
            end else begin
              r_start <= 1'b0;
              r_lcnt  <= LCNT_INIT;
            end
          end
        end
        LATCH: begin
          if (r_lcnt != 16'd0) r_lcnt <= r_lcnt - 16'd1;
          else if (w_go)       r_idx  <= '0;
          else                 r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // One-deep request queue while a frame is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_pend <= 1'b0;
    else if (w_lat_end)            r_pend <= 1'b0;
    else if (frame_req && r_busy)  r_pend <= 1'b1;
  end

endmodule
